// File: rtl/regfile_write_arbiter.sv
// Round-robin write-port arbiter for the register file, with bulk clear and illegal-address blocking.
// Latency: an accepted request appears on A3/WD3/RegWrite one cycle after the handshake; a clear takes NREGS+1 cycles.
// Backpressure: req_ready is low while hold, clr_req or CLEAR is active. Optional bypass ports: RFWA_BYPASS_EN.
module regfile_write_arbiter #(
    parameter int NREQ  = 3,
    parameter int AW    = 4,
    parameter int DW    = 32,
    parameter int NREGS = 13
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    input  logic               hold,
    input  logic               clr_req,
    output logic [AW-1:0]      A3,
    output logic [DW-1:0]      WD3,
    output logic               RegWrite,
    output logic               busy,
    output logic               clr_done,
    output logic               err_illegal,
    output logic [7:0]         err_count
`ifdef RFWA_BYPASS_EN
    ,
    input  logic [AW-1:0]      byp_addr,
    output logic               byp_hit,
    output logic [DW-1:0]      byp_data
`endif
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {ST_ARB = 1'b0, ST_CLEAR = 1'b1} state_t;

    state_t          state_q;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [AW-1:0]   cnt_q;
    logic [AW-1:0]   a3_q;
    logic [DW-1:0]   wd3_q;
    logic            we_q;
    logic            clr_done_q;
    logic            err_illegal_q;
    logic [7:0]      err_cnt_q;

    logic [NREQ-1:0] gnt;
    logic [PW-1:0]   gidx;
    logic            found;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_data;
    logic            sel_legal;

    // First valid requester at or after ptr, wrapping; suppressed outside ARB or when stalled/clearing.
    always_comb begin
        gnt   = '0;
        gidx  = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!found && (i == (int'(ptr_q) + k) % NREQ) && req_valid[i]) begin
                    gnt[i] = 1'b1;
                    gidx   = PW'(i);
                    found  = 1'b1;
                end
            end
        end
        if (state_q != ST_ARB || hold || clr_req) begin
            gnt   = '0;
            found = 1'b0;
        end
    end

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_addr = req_addr[i*AW +: AW];
                sel_data = req_data[i*DW +: DW];
            end
        end
        sel_legal = (int'(sel_addr) < NREGS);
        ptr_d     = (gidx == PW'(NREQ - 1)) ? '0 : gidx + PW'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_ARB;
            ptr_q         <= '0;
            cnt_q         <= '0;
            a3_q          <= '0;
            wd3_q         <= '0;
            we_q          <= 1'b0;
            clr_done_q    <= 1'b0;
            err_illegal_q <= 1'b0;
            err_cnt_q     <= '0;
        end else begin
            we_q          <= 1'b0;
            clr_done_q    <= 1'b0;
            err_illegal_q <= 1'b0;
            case (state_q)
                ST_ARB: begin
                    if (clr_req) begin
                        state_q <= ST_CLEAR;
                        cnt_q   <= '0;
                    end else if (found) begin
                        ptr_q <= ptr_d;
                        if (sel_legal) begin
                            we_q  <= 1'b1;
                            a3_q  <= sel_addr;
                            wd3_q <= sel_data;
                        end else begin
                            err_illegal_q <= 1'b1;
                            if (err_cnt_q != 8'hFF) begin
                                err_cnt_q <= err_cnt_q + 8'd1;
                            end
                        end
                    end
                end
                ST_CLEAR: begin
                    we_q  <= 1'b1;
                    a3_q  <= cnt_q;
                    wd3_q <= '0;
                    cnt_q <= cnt_q + AW'(1);
                    if (cnt_q == AW'(NREGS - 1)) begin
                        clr_done_q <= 1'b1;
                        state_q    <= ST_ARB;
                    end
                end
                default: state_q <= ST_ARB;
            endcase
        end
    end

    assign req_ready   = gnt;
    assign A3          = a3_q;
    assign WD3         = wd3_q;
    assign RegWrite    = we_q;
    assign busy        = (state_q == ST_CLEAR);
    assign clr_done    = clr_done_q;
    assign err_illegal = err_illegal_q;
    assign err_count   = err_cnt_q;

`ifdef RFWA_BYPASS_EN
    // Lets the read stage see a write the register file has not captured yet.
    assign byp_hit  = we_q && (a3_q == byp_addr);
    assign byp_data = wd3_q;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: vector table for arbitration, hand sequences for clear, saturation, reset.
module tb_regfile_write_arbiter;

    logic        clk;
    logic        rst;
    logic [2:0]  req_valid;
    logic [11:0] req_addr;
    logic [95:0] req_data;
    logic [2:0]  req_ready;
    logic        hold;
    logic        clr_req;
    logic [3:0]  A3;
    logic [31:0] WD3;
    logic        RegWrite;
    logic        busy;
    logic        clr_done;
    logic        err_illegal;
    logic [7:0]  err_count;
`ifdef RFWA_BYPASS_EN
    logic [3:0]  byp_addr;
    logic        byp_hit;
    logic [31:0] byp_data;
`endif

    regfile_write_arbiter dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
        .hold(hold), .clr_req(clr_req),
        .A3(A3), .WD3(WD3), .RegWrite(RegWrite),
        .busy(busy), .clr_done(clr_done), .err_illegal(err_illegal), .err_count(err_count)
`ifdef RFWA_BYPASS_EN
        , .byp_addr(byp_addr), .byp_hit(byp_hit), .byp_data(byp_data)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [2:0]  vld;
        logic [11:0] addr;
        logic [95:0] data;
        logic        hold;
        logic [2:0]  rdy;
        logic        we;
        logic [3:0]  a3;
        logic [31:0] wd;
        logic        err;
    } vec_t;

    localparam logic [31:0] DA = 32'hAAAA0000;
    localparam logic [31:0] DB = 32'hBBBB1111;
    localparam logic [31:0] DC = 32'hCCCC2222;
    localparam logic [95:0] DAT = {DC, DB, DA};
    localparam logic [11:0] ADR = {4'd9, 4'd8, 4'd7};

    vec_t vt[17];

    initial begin
        clk = 0; rst = 0;
        req_valid = '0; req_addr = '0; req_data = '0; hold = 0; clr_req = 0;
`ifdef RFWA_BYPASS_EN
        byp_addr = '0;
`endif
        // ptr starts at 0; after v2 it is back at 0 for the full rotation.
        vt[0]  = '{3'b001, {4'd0, 4'd0, 4'd5}, {64'd0, 32'hDEADBEEF}, 1'b0, 3'b001, 1'b1, 4'd5, 32'hDEADBEEF, 1'b0};
        vt[1]  = '{3'b000, ADR, DAT, 1'b0, 3'b000, 1'b0, 4'd5, 32'hDEADBEEF, 1'b0};
        vt[2]  = '{3'b100, ADR, DAT, 1'b0, 3'b100, 1'b1, 4'd9, DC, 1'b0};
        for (int r = 0; r < 2; r++) begin
            vt[3+3*r] = '{3'b111, ADR, DAT, 1'b0, 3'b001, 1'b1, 4'd7, DA, 1'b0};
            vt[4+3*r] = '{3'b111, ADR, DAT, 1'b0, 3'b010, 1'b1, 4'd8, DB, 1'b0};
            vt[5+3*r] = '{3'b111, ADR, DAT, 1'b0, 3'b100, 1'b1, 4'd9, DC, 1'b0};
        end
        vt[9]  = '{3'b111, ADR, DAT, 1'b1, 3'b000, 1'b0, 4'd9, DC, 1'b0};
        vt[10] = '{3'b111, ADR, DAT, 1'b0, 3'b001, 1'b1, 4'd7, DA, 1'b0};
        vt[11] = '{3'b001, ADR, DAT, 1'b0, 3'b001, 1'b1, 4'd7, DA, 1'b0};
        vt[12] = '{3'b001, ADR, DAT, 1'b0, 3'b001, 1'b1, 4'd7, DA, 1'b0};
        vt[13] = '{3'b010, {4'd9, 4'd14, 4'd7}, DAT, 1'b0, 3'b010, 1'b0, 4'd7, DA, 1'b1};
        vt[14] = '{3'b000, ADR, DAT, 1'b0, 3'b000, 1'b0, 4'd7, DA, 1'b0};
        vt[15] = '{3'b100, {4'd13, 4'd8, 4'd7}, DAT, 1'b0, 3'b100, 1'b0, 4'd7, DA, 1'b1};
        vt[16] = '{3'b001, {4'd9, 4'd8, 4'd12}, DAT, 1'b0, 3'b001, 1'b1, 4'd12, DA, 1'b0};

        #12;
        chk("rst_A3", 32'(A3), 0);
        chk("rst_WD3", WD3, 0);
        chk("rst_we", 32'(RegWrite), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(clr_done), 0);
        chk("rst_err", 32'(err_illegal), 0);
        chk("rst_errcnt", 32'(err_count), 0);
        @(negedge clk);
        rst = 1;

        for (int v = 0; v < 17; v++) begin
            req_valid = vt[v].vld; req_addr = vt[v].addr; req_data = vt[v].data; hold = vt[v].hold;
            #1;
            chk($sformatf("v%0d_rdy", v), 32'(req_ready), 32'(vt[v].rdy));
            @(posedge clk); #1;
            chk($sformatf("v%0d_we", v), 32'(RegWrite), 32'(vt[v].we));
            chk($sformatf("v%0d_a3", v), 32'(A3), 32'(vt[v].a3));
            chk($sformatf("v%0d_wd3", v), WD3, vt[v].wd);
            chk($sformatf("v%0d_err", v), 32'(err_illegal), 32'(vt[v].err));
            @(negedge clk);
        end
        chk("errcnt_after_table", 32'(err_count), 2);

        // Bulk clear requested together with hold and a pending request; ptr is 1 here.
        req_valid = 3'b001; req_addr = ADR; req_data = DAT; hold = 1; clr_req = 1;
        #1;
        chk("clr_req_rdy", 32'(req_ready), 0);
        for (int c = 1; c <= 15; c++) begin
            @(posedge clk); #1;
            if (c <= 14) begin
                chk($sformatf("clr%0d_busy", c), 32'(busy), (c <= 13) ? 1 : 0);
                chk($sformatf("clr%0d_done", c), 32'(clr_done), (c == 14) ? 1 : 0);
                chk($sformatf("clr%0d_we", c), 32'(RegWrite), (c >= 2) ? 1 : 0);
                if (c >= 2) begin
                    chk($sformatf("clr%0d_a3", c), 32'(A3), 32'(c - 2));
                    chk($sformatf("clr%0d_wd3", c), WD3, 0);
                end
            end else begin
                chk("post_clr_we", 32'(RegWrite), 1);
                chk("post_clr_a3", 32'(A3), 7);
                chk("post_clr_wd3", WD3, DA);
                chk("post_clr_busy", 32'(busy), 0);
                chk("post_clr_done", 32'(clr_done), 0);
            end
            @(negedge clk);
            hold = 0;
            clr_req = (c == 3);
            if (c == 15) req_valid = '0;
            #1;
            if (c <= 14) chk($sformatf("clr%0d_rdy", c), 32'(req_ready), (c == 14) ? 1 : 0);
        end

        // Saturation of the illegal-write counter.
        @(negedge clk);
        req_valid = 3'b010; req_addr = {4'd9, 4'd14, 4'd7};
        for (int n = 0; n < 300; n++) begin
            @(posedge clk); #1;
            if (n == 0) chk("sat_first", 32'(err_count), 3);
        end
        chk("sat_cnt", 32'(err_count), 255);
        chk("sat_pulse", 32'(err_illegal), 1);
        chk("sat_we", 32'(RegWrite), 0);
        @(negedge clk);
        req_valid = '0;

        // Reset in the middle of a clear.
        @(negedge clk); clr_req = 1;
        @(negedge clk); clr_req = 0;
        repeat (4) @(negedge clk);
        chk("midclr_busy_pre", 32'(busy), 1);
        #2 rst = 0;
        #1;
        chk("midrst_A3", 32'(A3), 0);
        chk("midrst_WD3", WD3, 0);
        chk("midrst_we", 32'(RegWrite), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_done", 32'(clr_done), 0);
        chk("midrst_err", 32'(err_illegal), 0);
        chk("midrst_errcnt", 32'(err_count), 0);
        @(negedge clk);
        rst = 1;
        req_valid = 3'b111; req_addr = ADR; req_data = DAT;
        #1;
        chk("after_rst_rdy", 32'(req_ready), 1);
        @(posedge clk); #1;
        chk("after_rst_we", 32'(RegWrite), 1);
        chk("after_rst_a3", 32'(A3), 7);
        chk("after_rst_busy", 32'(busy), 0);
`ifdef RFWA_BYPASS_EN
        byp_addr = 4'd7;
        #1;
        chk("byp_hit7", 32'(byp_hit), 1);
        chk("byp_data7", byp_data, DA);
        byp_addr = 4'd6;
        #1;
        chk("byp_hit6", 32'(byp_hit), 0);
`endif
        @(negedge clk);
        req_valid = '0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Write-port controller for the 13-entry register file. It shares the file's single write port (A3/WD3/RegWrite) among NREQ write-back requesters (ALU result, memory load, host/debug) using round-robin arbitration with a valid/ready handshake. It also runs a bulk-clear sequence that zeroes every register, and it blocks writes to addresses that do not exist. It sits between the execute/memory write-back stages and the register file.

## Interface
Parameters:
- NREQ, 3, number of requesters (index 0 = ALU, 1 = load, 2 = host)
- AW, 4, register address width
- DW, 32, data width
- NREGS, 13, number of implemented registers; legal addresses are 0..NREGS-1

Ports:
- clk  in  1  clock; all state is updated on the rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  per-requester write request
- req_addr  in  NREQ*AW  packed destination addresses; requester i occupies bits [i*AW +: AW]
- req_data  in  NREQ*DW  packed write data; requester i occupies bits [i*DW +: DW]
- req_ready  out  NREQ  one-hot grant; a transfer occurs when req_valid[i] & req_ready[i]
- hold  in  1  pipeline stall; blocks all grants while high
- clr_req  in  1  single-cycle pulse that starts the bulk clear
- A3  out  AW  register-file write address (registered)
- WD3  out  DW  register-file write data (registered)
- RegWrite  out  1  register-file write enable (registered)
- busy  out  1  high while the CLEAR sequence is running
- clr_done  out  1  one-cycle pulse when the clear sequence completes
- err_illegal  out  1  one-cycle pulse after an accepted write to an address >= NREGS
- err_count  out  8  saturating count of illegal writes

## Operation
- FSM states: ARB (the reset state) and CLEAR.
- ARB, arbitration:
  - Search order starts at the pointer ptr and wraps modulo NREQ.
  - req_ready[i] is combinational: high only for the first i in search order with req_valid[i]=1, and only when hold=0 and clr_req=0.
  - After a grant to index i, ptr becomes (i+1) mod NREQ. With no grant, ptr is unchanged.
- Accepted legal write: in the next cycle RegWrite=1, A3=addr, WD3=data.
- Accepted illegal write (addr >= NREGS):
  - The transfer completes (ready is still given) and ptr advances.
  - In the next cycle RegWrite=0 and err_illegal=1.
  - err_count increments and saturates at 255.
- No accepted transfer: RegWrite=0 next cycle. A3 and WD3 hold their previous values.
- clr_req seen in ARB:
  - No grant is given in that cycle.
  - Enter CLEAR with the clear counter cnt=0.
  - clr_req takes priority over simultaneous requests and over hold.
- CLEAR:
  - Each cycle drives RegWrite=1, A3=cnt, WD3=0 (registered), then cnt increments.
  - All req_ready are low. hold is ignored.
  - After the write of NREGS-1, clr_done pulses alongside that final write and the FSM returns to ARB.
  - ptr is preserved across CLEAR.
  - clr_req during CLEAR is ignored.
- busy=1 in every cycle the FSM is in CLEAR.
- Reset mid-operation: immediate return to ARB with every output at its reset value. A partial clear is abandoned.

## Timing
- Reset values: A3=0, WD3=0, RegWrite=0, busy=0, clr_done=0, err_illegal=0, err_count=0, ptr=0, FSM=ARB.
- Request latency:
  - Handshake in cycle N.
  - RegWrite/A3/WD3 are valid during cycle N+1.
  - The register file captures the value at the end of N+1, and it is readable from N+2.
- Throughput: one write per cycle. Back-to-back grants are allowed, and the same requester may be granted consecutively if it is the only one valid.
- Clear timing:
  - clr_req at cycle N.
  - busy=1 in cycles N+1..N+NREGS.
  - Writes to addresses 0..NREGS-1 appear in cycles N+2..N+NREGS+1.
  - clr_done pulses in cycle N+NREGS+1.
  - The first grant is possible in N+NREGS+1.
- The requester must hold req_addr/req_data stable while req_valid is high and ready is low.

## Configuration
- RFWA_BYPASS_EN defined adds three ports: byp_addr (in, AW), byp_hit (out, 1) and byp_data (out, DW).
  - byp_hit = RegWrite & (A3 == byp_addr), combinational from the output registers.
  - byp_data = WD3.
  - Purpose: the read stage can forward a write that the register file has not yet captured.
- Undefined: these ports and their logic are absent. All other behaviour is identical.

## Test plan
- Reset, then req_valid=3'b001, addr=5, data=32'hDEADBEEF in one cycle → req_ready=3'b001. Next cycle RegWrite=1, A3=5, WD3=32'hDEADBEEF. The cycle after, RegWrite=0.
- All three requesters held valid for 6 cycles from ptr=0 → grant order 0,1,2,0,1,2 with no idle cycles.
- hold=1 with all requesters valid → req_ready=0 and RegWrite=0 in the following cycle. Release hold → the grant goes to the index at ptr.
- Requester 1 writes addr=14 → ready given, RegWrite stays 0, err_illegal pulses once, err_count=1. 300 such writes → err_count=255.
- clr_req while requester 0 is valid → no grant, busy high for 13 cycles, addresses 0..12 written with 0, clr_done coincides with A3=12. Requester 0 is granted on the clr_done cycle. Assert rst low mid-clear → all outputs return to 0 immediately.
- With RFWA_BYPASS_EN: a write to 7 is in flight and byp_addr=7 → byp_hit=1 and byp_data equals the data. With byp_addr=6 → byp_hit=0.
